// File: rtl/rv32im_pkg.sv
// Shared definitions for the rv32im muldiv unit and its front-end arbiter:
// funct3 encodings of the M-extension operations and the arbiter states.
package rv32im_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [2:0] {
        ARB_INIT,
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_e;

endpackage

// File: rtl/rv_rr_picker.sv
// Combinational round-robin picker.
// Scans upward from last_grant_i+1 (mod NREQ) and selects the first eligible
// requester.
//   eligible_i   : per-requester eligibility
//   last_grant_i : index of the previous winner
//   grant_o      : one-hot winner (all zero when nothing is eligible)
//   index_o      : binary index of the winner
//   any_o        : at least one requester is eligible
module rv_rr_picker #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] eligible_i,
    input  logic [IDXW-1:0] last_grant_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDXW-1:0] index_o,
    output logic            any_o
);

    always_comb begin
        int unsigned cand;
        cand    = 0;
        grant_o = '0;
        index_o = '0;
        any_o   = 1'b0;
        // Offset NREQ wraps back onto last_grant itself, so it is checked last.
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = (32'(last_grant_i) + off) % NREQ;
            if (!any_o && eligible_i[IDXW'(cand)]) begin
                any_o                  = 1'b1;
                grant_o[IDXW'(cand)]   = 1'b1;
                index_o                = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/rv32im_muldiv_arbiter.sv
// Shares one rv32im_muldiv unit between NREQ requesters with round-robin
// grants and a single operation in flight. Handles per-requester kill, a
// watchdog on the shared unit and the clear pulse after reset.
//   clk_i, reset_ni         : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o : request handshake (ready is a one-hot pulse)
//   req_op_i/op1/op2        : per-requester funct3 and operands
//   kill_i                  : flush requester k (pending or in flight)
//   resp_valid_o            : one-hot, one-cycle response pulse
//   resp_data_o/resp_err_o  : result and timeout flag, held between pulses
//   md_*_o / md_*_i         : connection to the shared muldiv unit
module rv32im_muldiv_arbiter
    import rv32im_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [3*NREQ-1:0]    req_op_i,
    input  logic [XLEN*NREQ-1:0] req_op1_i,
    input  logic [XLEN*NREQ-1:0] req_op2_i,
    input  logic [NREQ-1:0]      kill_i,
    output logic [NREQ-1:0]      resp_valid_o,
    output logic [XLEN-1:0]      resp_data_o,
    output logic                 resp_err_o,
    output logic                 md_clear_o,
    output logic                 md_data_ready_o,
    output logic [2:0]           md_operation_o,
    output logic [XLEN-1:0]      md_operand1_o,
    output logic [XLEN-1:0]      md_operand2_o,
    input  logic [XLEN-1:0]      md_result_i,
    input  logic                 md_data_ready_i,
    input  logic                 md_busy_i
);

    localparam int unsigned     IDXW    = $clog2(NREQ);
    localparam int unsigned     WDW     = $clog2(TIMEOUT);
    localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] ONE     = NREQ'(1);

    arb_state_e        state_q;
    logic [IDXW-1:0]   owner_q;
    logic [IDXW-1:0]   last_q;
    logic [WDW-1:0]    wdog_q;
    logic [NREQ-1:0]   req_ready_q;
    logic [NREQ-1:0]   resp_valid_q;
    logic [XLEN-1:0]   resp_data_q;
    logic              resp_err_q;
    logic [XLEN-1:0]   res_q;
    logic              err_q;
    logic              md_clear_q;
    logic              md_data_ready_q;
    logic [2:0]        md_op_q;
    logic [XLEN-1:0]   md_op1_q;
    logic [XLEN-1:0]   md_op2_q;

    logic [NREQ-1:0]   eligible;
    logic [NREQ-1:0]   pick_grant;
    logic [IDXW-1:0]   pick_index;
    logic              pick_any;
    logic [2:0]        sel_op;
    logic [XLEN-1:0]   sel_op1;
    logic [XLEN-1:0]   sel_op2;
    logic              owner_kill;

    assign eligible   = req_valid_i & ~kill_i;
    assign owner_kill = kill_i[owner_q];

    rv_rr_picker #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_picker (
        .eligible_i   (eligible),
        .last_grant_i (last_q),
        .grant_o      (pick_grant),
        .index_o      (pick_index),
        .any_o        (pick_any)
    );

    always_comb begin
        sel_op  = '0;
        sel_op1 = '0;
        sel_op2 = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (pick_grant[k]) begin
                sel_op  = req_op_i[3*k +: 3];
                sel_op1 = req_op1_i[XLEN*k +: XLEN];
                sel_op2 = req_op2_i[XLEN*k +: XLEN];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q         <= ARB_INIT;
            owner_q         <= '0;
            last_q          <= IDXW'(NREQ - 1);
            wdog_q          <= '0;
            req_ready_q     <= '0;
            resp_valid_q    <= '0;
            resp_data_q     <= '0;
            resp_err_q      <= 1'b0;
            res_q           <= '0;
            err_q           <= 1'b0;
            md_clear_q      <= 1'b1;
            md_data_ready_q <= 1'b0;
            md_op_q         <= '0;
            md_op1_q        <= '0;
            md_op2_q        <= '0;
        end else begin
            req_ready_q     <= '0;
            resp_valid_q    <= '0;
            md_clear_q      <= 1'b0;
            md_data_ready_q <= 1'b0;
            unique case (state_q)
                ARB_INIT: state_q <= ARB_IDLE;
                ARB_IDLE: begin
                    if (pick_any) begin
                        req_ready_q <= pick_grant;
                        md_op_q     <= sel_op;
                        md_op1_q    <= sel_op1;
                        md_op2_q    <= sel_op2;
                        owner_q     <= pick_index;
                        last_q      <= pick_index;
                        state_q     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (owner_kill) begin
                        md_clear_q <= 1'b1;
                        state_q    <= ARB_IDLE;
                    end else if (!md_busy_i) begin
                        md_data_ready_q <= 1'b1;
                        wdog_q          <= '0;
                        state_q         <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    wdog_q <= wdog_q + 1'b1;
                    // Kill beats a returning result, which beats the watchdog.
                    if (owner_kill) begin
                        md_clear_q <= 1'b1;
                        state_q    <= ARB_IDLE;
                    end else if (md_data_ready_i) begin
                        res_q   <= md_result_i;
                        err_q   <= 1'b0;
                        state_q <= ARB_RESP;
                    end else if (wdog_q == WD_LAST) begin
                        md_clear_q <= 1'b1;
                        res_q      <= '0;
                        err_q      <= 1'b1;
                        state_q    <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    // The pulse is launched from the RESP exit edge so a kill
                    // seen during RESP can still suppress it; data/err only
                    // change together with a delivered pulse.
                    if (!owner_kill) begin
                        resp_valid_q <= ONE << owner_q;
                        resp_data_q  <= res_q;
                        resp_err_q   <= err_q;
                    end
                    state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_INIT;
            endcase
        end
    end

    assign req_ready_o     = req_ready_q;
    assign resp_valid_o    = resp_valid_q;
    assign resp_data_o     = resp_data_q;
    assign resp_err_o      = resp_err_q;
    assign md_clear_o      = md_clear_q;
    assign md_data_ready_o = md_data_ready_q;
    assign md_operation_o  = md_op_q;
    assign md_operand1_o   = md_op1_q;
    assign md_operand2_o   = md_op2_q;

endmodule

// File: tb/tb_rv32im_muldiv_arbiter.sv
// Directed bench for rv32im_muldiv_arbiter with a small behavioural muldiv
// model (programmable latency, optional silence to provoke the watchdog).
module tb_rv32im_muldiv_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready_o;
    logic [5:0]  req_op;
    logic [63:0] req_op1;
    logic [63:0] req_op2;
    logic [1:0]  kill;
    logic [1:0]  resp_valid_o;
    logic [31:0] resp_data_o;
    logic        resp_err_o;
    logic        md_clear_o;
    logic        md_data_ready_o;
    logic [2:0]  md_operation_o;
    logic [31:0] md_operand1_o;
    logic [31:0] md_operand2_o;
    logic [31:0] mdl_res;
    logic        mdl_rdy;
    logic        mdl_busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned lat    = 2;
    bit          mute   = 1'b0;
    int unsigned clr_cnt     = 0;
    int unsigned overlap_cnt = 0;

    rv32im_muldiv_arbiter #(
        .XLEN    (32),
        .NREQ    (2),
        .TIMEOUT (8)
    ) dut (
        .clk_i           (clk),
        .reset_ni        (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready_o),
        .req_op_i        (req_op),
        .req_op1_i       (req_op1),
        .req_op2_i       (req_op2),
        .kill_i          (kill),
        .resp_valid_o    (resp_valid_o),
        .resp_data_o     (resp_data_o),
        .resp_err_o      (resp_err_o),
        .md_clear_o      (md_clear_o),
        .md_data_ready_o (md_data_ready_o),
        .md_operation_o  (md_operation_o),
        .md_operand1_o   (md_operand1_o),
        .md_operand2_o   (md_operand2_o),
        .md_result_i     (mdl_res),
        .md_data_ready_i (mdl_rdy),
        .md_busy_i       (mdl_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] f_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 0) ? a : 32'($signed(a) % $signed(b));
            3'b111:  return (b == 0) ? a : a % b;
            default: return a * b;
        endcase
    endfunction

    // Muldiv model: starts on data_ready, answers lat cycles later.
    logic [31:0] mdl_pend;
    int unsigned mdl_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_rdy <= 1'b0; mdl_busy <= 1'b0; mdl_cnt <= 0; mdl_res <= '0; mdl_pend <= '0;
        end else if (md_clear_o) begin
            mdl_rdy <= 1'b0; mdl_busy <= 1'b0; mdl_cnt <= 0;
        end else begin
            mdl_rdy <= 1'b0;
            if (md_data_ready_o) begin
                mdl_busy <= 1'b1;
                mdl_cnt  <= lat;
                mdl_pend <= f_model(md_operation_o, md_operand1_o, md_operand2_o);
            end else if (mdl_busy) begin
                mdl_cnt <= mdl_cnt - 1;
                if (mdl_cnt == 1) begin
                    mdl_busy <= 1'b0;
                    if (!mute) begin
                        mdl_rdy <= 1'b1;
                        mdl_res <= mdl_pend;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (md_clear_o) clr_cnt <= clr_cnt + 1;
        if (md_clear_o && md_data_ready_o) overlap_cnt <= overlap_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[3*k +: 3]   = op;
        req_op1[32*k +: 32] = a;
        req_op2[32*k +: 32] = b;
    endtask

    task automatic wait_ready(input string tag, input int unsigned maxc, output int unsigned n);
        n = 0;
        while (req_ready_o == 2'b00 && n < maxc) begin
            tick();
            n++;
        end
        chk({tag, "_bound"}, 64'(req_ready_o != 2'b00), 64'd1);
    endtask

    task automatic wait_resp(input string tag, input int unsigned maxc, output int unsigned n);
        n = 0;
        while (resp_valid_o == 2'b00 && n < maxc) begin
            tick();
            n++;
        end
        chk({tag, "_bound"}, 64'(resp_valid_o != 2'b00), 64'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        kill      = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int unsigned n;
        int unsigned c0;
        int unsigned seen;
        rst_n = 1'b0; req_valid = '0; req_op = '0; req_op1 = '0; req_op2 = '0; kill = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clear", md_clear_o, 1);
        chk("rst_ready", req_ready_o, 0);
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_md_ready", md_data_ready_o, 0);
        chk("rst_resp_data", resp_data_o, 0);
        chk("rst_resp_err", resp_err_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("init_clear_hi", md_clear_o, 1);
        tick();
        chk("init_clear_lo", md_clear_o, 0);

        // 1: single DIVU 100/7 from requester 0
        set_req(0, 3'b101, 32'd100, 32'd7);
        req_valid = 2'b01;
        wait_ready("t1_ready", 10, n);
        chk("t1_ready", req_ready_o, 2'b01);
        chk("t1_op", md_operation_o, 3'b101);
        chk("t1_opa", md_operand1_o, 100);
        chk("t1_opb", md_operand2_o, 7);
        req_valid = 2'b00;
        wait_resp("t1_resp", 20, n);
        chk("t1_latency", n, 6);
        chk("t1_valid", resp_valid_o, 2'b01);
        chk("t1_data", resp_data_o, 14);
        chk("t1_err", resp_err_o, 0);
        tick();
        chk("t1_pulse", resp_valid_o, 0);
        chk("t1_hold", resp_data_o, 14);

        // 2: both requesters always valid, grants alternate starting at 0
        apply_reset();
        set_req(0, 3'b110, 32'hFFFF_FFF9, 32'd2);
        set_req(1, 3'b000, 32'd6, 32'd7);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_ready("t2_ready", 10, n);
            chk("t2_grant", req_ready_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            wait_resp("t2_resp", 20, n);
            chk("t2_valid", resp_valid_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2_data", resp_data_o, (i % 2 == 0) ? 32'hFFFF_FFFF : 32'd42);
        end
        req_valid = 2'b00;

        // 3: kill requester 0 in WAIT; pending requester 1 follows quickly
        set_req(0, 3'b100, 32'd1000, 32'd3);
        set_req(1, 3'b000, 32'd6, 32'd7);
        req_valid = 2'b11;
        wait_ready("t3_ready0", 10, n);
        chk("t3_grant0", req_ready_o, 2'b01);
        req_valid = 2'b10;
        tick();
        tick();
        c0   = clr_cnt;
        kill = 2'b01;
        tick();
        chk("t3_clear", md_clear_o, 1);
        kill = 2'b00;
        wait_ready("t3_ready1", 2, n);
        chk("t3_within2", 64'(n <= 2), 1);
        chk("t3_grant1", req_ready_o, 2'b10);
        chk("t3_clear_once", md_clear_o, 0);
        req_valid = 2'b00;
        wait_resp("t3_resp", 20, n);
        chk("t3_valid", resp_valid_o, 2'b10);
        chk("t3_data", resp_data_o, 42);
        chk("t3_clear_count", clr_cnt - c0, 1);

        // 4: silent muldiv, watchdog aborts after 8 WAIT cycles
        mute = 1'b1;
        set_req(0, 3'b000, 32'd3, 32'd5);
        req_valid = 2'b01;
        wait_ready("t4_ready", 10, n);
        chk("t4_grant", req_ready_o, 2'b01);
        req_valid = 2'b00;
        c0 = clr_cnt;
        n  = 0;
        while (!md_clear_o && n < 20) begin
            tick();
            n++;
        end
        chk("t4_wait_cycles", n - 1, 8);
        chk("t4_no_overlap", md_data_ready_o, 0);
        tick();
        chk("t4_valid", resp_valid_o, 2'b01);
        chk("t4_err", resp_err_o, 1);
        chk("t4_data", resp_data_o, 0);
        chk("t4_clear_count", clr_cnt - c0, 1);
        mute = 1'b0;

        // 5a: result lands on the timeout cycle, data path wins
        lat = 6;
        set_req(1, 3'b000, 32'd6, 32'd7);
        req_valid = 2'b10;
        wait_ready("t5a_ready", 10, n);
        chk("t5a_grant", req_ready_o, 2'b10);
        req_valid = 2'b00;
        c0 = clr_cnt;
        wait_resp("t5a_resp", 30, n);
        chk("t5a_latency", n, 10);
        chk("t5a_valid", resp_valid_o, 2'b10);
        chk("t5a_err", resp_err_o, 0);
        chk("t5a_data", resp_data_o, 42);
        chk("t5a_no_clear", clr_cnt - c0, 0);

        // 5b: result, timeout and kill all in the same cycle
        set_req(0, 3'b101, 32'd100, 32'd7);
        req_valid = 2'b01;
        wait_ready("t5b_ready", 10, n);
        chk("t5b_grant", req_ready_o, 2'b01);
        req_valid = 2'b00;
        repeat (8) tick();
        kill = 2'b01;
        tick();
        chk("t5b_clear", md_clear_o, 1);
        kill = 2'b00;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid_o != 2'b00) seen++;
            tick();
        end
        chk("t5b_no_resp", seen, 0);
        lat = 2;

        // 6: asynchronous reset during WAIT, then recovery
        set_req(1, 3'b101, 32'd100, 32'd7);
        req_valid = 2'b10;
        wait_ready("t6_ready", 10, n);
        chk("t6_grant", req_ready_o, 2'b10);
        req_valid = 2'b00;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_clear", md_clear_o, 1);
        chk("t6_async_mdrdy", md_data_ready_o, 0);
        chk("t6_async_op", md_operation_o, 0);
        chk("t6_async_opa", md_operand1_o, 0);
        chk("t6_async_data", resp_data_o, 0);
        chk("t6_async_valid", resp_valid_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_init_clear_hi", md_clear_o, 1);
        tick();
        chk("t6_init_clear_lo", md_clear_o, 0);
        set_req(0, 3'b101, 32'd100, 32'd7);
        req_valid = 2'b01;
        wait_ready("t6_ready2", 10, n);
        chk("t6_grant2", req_ready_o, 2'b01);
        req_valid = 2'b00;
        wait_resp("t6_resp", 20, n);
        chk("t6_valid", resp_valid_o, 2'b01);
        chk("t6_data", resp_data_o, 14);
        chk("t6_err", resp_err_o, 0);

        tick();
        chk("clear_ready_overlap", overlap_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32im_muldiv_arbiter.md
Name: rv32im_muldiv_arbiter

Overview:
Shares one rv32im_muldiv unit between NREQ requesters, e.g. the integer pipeline and a debug or accelerator port. Each requester gets a valid/ready request handshake and a one-cycle response pulse. Grants are round-robin with one operation in flight at a time. The block also handles per-requester kill (flush), a watchdog timeout on the shared unit, and the unit's clear sequencing at startup.

Parameters:
XLEN, 32, operand/result width
NREQ, 2, number of requesters (>=2)
TIMEOUT, 64, max cycles in WAIT before abort (>=2)

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
req_valid_i  in  NREQ  request pending, payload held stable until ready
req_ready_o  out  NREQ  one-hot accept pulse
req_op_i  in  3*NREQ  funct3 per requester, slice k = [3k+2:3k]
req_op1_i  in  XLEN*NREQ  operand1 per requester
req_op2_i  in  XLEN*NREQ  operand2 per requester
kill_i  in  NREQ  flush requester k (cancels pending or in-flight op)
resp_valid_o  out  NREQ  one-hot, one-cycle response pulse
resp_data_o  out  XLEN  result, valid with resp_valid_o
resp_err_o  out  1  timeout abort flag, valid with resp_valid_o
md_clear_o  out  1  to muldiv clear_i
md_data_ready_o  out  1  to muldiv data_ready_i
md_operation_o  out  3  to muldiv operation_i
md_operand1_o  out  XLEN  to muldiv operand1_i
md_operand2_o  out  XLEN  to muldiv operand2_i
md_result_i  in  XLEN  from muldiv result_o
md_data_ready_i  in  1  from muldiv data_ready_o
md_busy_i  in  1  from muldiv busy_o

Behaviour:
- All outputs registered.
- Reset values:
  - md_clear_o=1; all other outputs 0.
  - state=INIT; owner=0; last_grant=NREQ-1, so requester 0 wins first; watchdog=0.
- INIT: md_clear_o=1 for exactly one clock edge after reset release, then ->IDLE with md_clear_o=0.
- IDLE:
  - Eligible requesters: req_valid_i & ~kill_i.
  - Winner is the first eligible index scanning upward from last_grant+1 (mod NREQ).
  - On the grant cycle: req_ready_o[w]=1 (next cycle, one pulse); latch op/operands into md_* regs; owner=w; last_grant=w; ->ISSUE.
  - No eligible requester: stay in IDLE.
- ISSUE: md_data_ready_o=1 for one cycle, only if md_busy_i=0; otherwise hold in ISSUE. Then ->WAIT, watchdog cleared.
- WAIT:
  - Watchdog increments each cycle.
  - md_data_ready_i=1: capture md_result_i ->RESP, err=0.
  - Watchdog reaches TIMEOUT-1 with no md_data_ready_i: md_clear_o=1 one cycle, data=0, err=1 ->RESP.
  - md_data_ready_i and timeout in the same cycle: the data path wins, err=0.
- RESP: resp_valid_o[owner]=1, resp_data_o and resp_err_o driven, one cycle ->IDLE. New grant earliest in the cycle after RESP.
- Kill rules:
  - kill_i[owner] in ISSUE or WAIT: md_clear_o=1 one cycle, no response, ->IDLE. Takes priority over md_data_ready_i in the same cycle.
  - kill_i[owner] in RESP: resp_valid_o suppressed.
  - kill of a non-owner: masks only its eligibility.
- md_clear_o is never asserted together with md_data_ready_o.
- Minimum latency, grant to resp_valid: 3 + muldiv latency cycles.
- Reset mid-operation: async return to reset values, then the INIT clear pulse re-clears the muldiv.
- resp_data_o and resp_err_o hold their last value outside a pulse.

Decomposition:
- Shared package rv32im_pkg:
  - funct3 localparams MUL..REMU.
  - Arbiter state encoding INIT/IDLE/ISSUE/WAIT/RESP.
- One sub-module, rv_rr_picker: combinational round-robin select.
  - Inputs: eligible[NREQ], last_grant.
  - Outputs: grant one-hot, index, any.
  - Reusable by other shared-resource arbiters.

Test Plan:
1. Reset then idle -> md_clear_o=1 for exactly one cycle after reset_ni rises, then 0. Req0 DIVU 100/7 -> md_operation_o=3'b101, resp_valid_o=2'b01, resp_data_o=14, resp_err_o=0.
2. Both requesters valid every cycle: req0 REM -7/2, req1 MUL 6/7 -> grants alternate 0,1,0,1. Responses -1 and 42 with the matching one-hot resp_valid_o.
3. kill_i[0] asserted in WAIT of a DIV 1000/3 -> md_clear_o single pulse, no resp_valid_o. A pending req1 is granted within 2 cycles.
4. Muldiv model never raises data_ready, TIMEOUT=8 -> md_clear_o pulse after 8 WAIT cycles. resp_valid_o[owner]=1, resp_err_o=1, resp_data_o=0.
5. md_data_ready_i arriving on the exact timeout cycle -> resp_err_o=0 with the real result. A kill in the same cycle -> no response.
6. reset_ni dropped asynchronously during WAIT -> outputs reach reset values without a clock edge. The INIT clear pulse follows, and the next request completes correctly.
